// File: rtl/video_timing_gen.sv
// Programmable raster generator: pixel-enable prescaler, H/V counters and registered sync/blank/DE.
// Define VTG_TESTPAT_EN to add registered colour-bar R/G/B outputs.
module video_timing_gen #(
    parameter logic HS_NEG = 1'b1,
    parameter logic VS_NEG = 1'b1
) (
    input  logic        CLK_VIDEO,
    input  logic        RESET_N,
    input  logic [3:0]  CE_DIV,
    input  logic [11:0] H_ACTIVE,
    input  logic [11:0] H_FP,
    input  logic [11:0] H_SYNC,
    input  logic [11:0] H_BP,
    input  logic [11:0] V_ACTIVE,
    input  logic [11:0] V_FP,
    input  logic [11:0] V_SYNC,
    input  logic [11:0] V_BP,
    output logic        CE_PIXEL,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        HBLANK,
    output logic        VBLANK,
    output logic        DE,
    output logic [11:0] HCNT,
    output logic [11:0] VCNT,
    output logic        FRAME_START
`ifdef VTG_TESTPAT_EN
    ,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic        load;
    logic [3:0]  pc;
    logic [11:0] h, v;
    logic [11:0] ha_s, hf_s, hsy_s, hb_s, va_s, vf_s, vsy_s, vb_s;
    logic [13:0] htot, vtot, htot_in, vtot_in;
    logic [13:0] h14, v14, hs_start, hs_end, vs_start, vs_end;
    logic        in_valid, vld_p0, h_last, v_last, frame_end;
    logic        hblank_p0, vblank_p0, hsync_p0, vsync_p0, de_p0, fs_p0;

    function automatic logic [13:0] sum4(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c, input logic [11:0] d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    function automatic logic sync_level(input logic active, input logic neg);
        return active ^ neg;
    endfunction

    assign htot_in  = sum4(H_ACTIVE, H_FP, H_SYNC, H_BP);
    assign vtot_in  = sum4(V_ACTIVE, V_FP, V_SYNC, V_BP);
    assign htot     = sum4(ha_s, hf_s, hsy_s, hb_s);
    assign vtot     = sum4(va_s, vf_s, vsy_s, vb_s);
    assign in_valid = (htot_in <= 14'd4096) && (vtot_in <= 14'd4096) &&
                      (H_ACTIVE != 12'd0) && (H_SYNC != 12'd0) &&
                      (V_ACTIVE != 12'd0) && (V_SYNC != 12'd0);

    assign vld_p0    = (state == RUN) && (pc == CE_DIV);
    assign h14       = {2'b00, h};
    assign v14       = {2'b00, v};
    assign h_last    = (h14 == htot - 14'd1);
    assign v_last    = (v14 == vtot - 14'd1);
    assign frame_end = vld_p0 && h_last && v_last;

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Shadows are only ever reloaded at a frame boundary, so a frame never tears.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (in_valid) load = 1'b1;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            pc    <= 4'd0;
            h     <= 12'd0;
            v     <= 12'd0;
            ha_s  <= 12'd0; hf_s <= 12'd0; hsy_s <= 12'd0; hb_s <= 12'd0;
            va_s  <= 12'd0; vf_s <= 12'd0; vsy_s <= 12'd0; vb_s <= 12'd0;
        end else begin
            if (load) begin
                ha_s <= H_ACTIVE; hf_s <= H_FP; hsy_s <= H_SYNC; hb_s <= H_BP;
                va_s <= V_ACTIVE; vf_s <= V_FP; vsy_s <= V_SYNC; vb_s <= V_BP;
            end
            if (state == IDLE) begin
                pc <= 4'd0;
                h  <= 12'd0;
                v  <= 12'd0;
            end else if (vld_p0) begin
                pc <= 4'd0;
                if (h_last) begin
                    h <= 12'd0;
                    v <= v_last ? 12'd0 : v + 12'd1;
                end else begin
                    h <= h + 12'd1;
                end
            end else begin
                pc <= pc + 4'd1;
            end
        end
    end

    // Stage p0: decode of the current pixel (h, v) against the shadowed timing.
    assign hs_start  = {2'b00, ha_s} + {2'b00, hf_s};
    assign hs_end    = hs_start + {2'b00, hsy_s};
    assign vs_start  = {2'b00, va_s} + {2'b00, vf_s};
    assign vs_end    = vs_start + {2'b00, vsy_s};
    assign hblank_p0 = (h >= ha_s);
    assign vblank_p0 = (v >= va_s);
    assign hsync_p0  = (h14 >= hs_start) && (h14 < hs_end);
    assign vsync_p0  = (v14 >= vs_start) && (v14 < vs_end);
    assign de_p0     = ~hblank_p0 & ~vblank_p0;
    assign fs_p0     = (h == 12'd0) && (v == 12'd0);

    // Stage p1: output registers, loaded on the tick edge only.
    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            CE_PIXEL    <= 1'b0;
            HSYNC       <= HS_NEG;
            VSYNC       <= VS_NEG;
            HBLANK      <= 1'b1;
            VBLANK      <= 1'b1;
            DE          <= 1'b0;
            HCNT        <= 12'd0;
            VCNT        <= 12'd0;
            FRAME_START <= 1'b0;
        end else if (state == IDLE) begin
            CE_PIXEL    <= 1'b0;
            HSYNC       <= HS_NEG;
            VSYNC       <= VS_NEG;
            HBLANK      <= 1'b1;
            VBLANK      <= 1'b1;
            DE          <= 1'b0;
            HCNT        <= 12'd0;
            VCNT        <= 12'd0;
            FRAME_START <= 1'b0;
        end else begin
            CE_PIXEL <= vld_p0;
            if (vld_p0) begin
                HSYNC       <= sync_level(hsync_p0, HS_NEG);
                VSYNC       <= sync_level(vsync_p0, VS_NEG);
                HBLANK      <= hblank_p0;
                VBLANK      <= vblank_p0;
                DE          <= de_p0;
                HCNT        <= h;
                VCNT        <= v;
                FRAME_START <= fs_p0;
            end
        end
    end

`ifdef VTG_TESTPAT_EN
    logic [11:0] bw, bar_cnt;
    logic [2:0]  bar_idx;

    function automatic logic [2:0] sat_inc3(input logic [2:0] x);
        return (x == 3'd7) ? 3'd7 : x + 3'd1;
    endfunction

    assign bw = (ha_s[11:3] == 9'd0) ? 12'd1 : {3'b000, ha_s[11:3]};

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            bar_cnt <= 12'd0;
            bar_idx <= 3'd0;
            R <= 8'h00; G <= 8'h00; B <= 8'h00;
        end else if (state == IDLE) begin
            bar_cnt <= 12'd0;
            bar_idx <= 3'd0;
            R <= 8'h00; G <= 8'h00; B <= 8'h00;
        end else if (vld_p0) begin
            R <= de_p0 ? {8{~bar_idx[1]}} : 8'h00;
            G <= de_p0 ? {8{~bar_idx[2]}} : 8'h00;
            B <= de_p0 ? {8{~bar_idx[0]}} : 8'h00;
            if (h_last) begin
                bar_cnt <= 12'd0;
                bar_idx <= 3'd0;
            end else if (!hblank_p0) begin
                if (bar_cnt == bw - 12'd1) begin
                    bar_cnt <= 12'd0;
                    bar_idx <= sat_inc3(bar_idx);
                end else begin
                    bar_cnt <= bar_cnt + 12'd1;
                end
            end
        end
    end
`endif

endmodule
